// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce and packed-BCD digit entry
module keypad_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] bcd_out,
  output logic [2:0]  digit_count
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  // key code per snapshot bit {row, col}, bit 0 = r0c0
  localparam logic [63:0] KEYMAP = {4'hD, 4'hF, 4'h0, 4'hE,
                                    4'hC, 4'h9, 4'h8, 4'h7,
                                    4'hB, 4'h6, 4'h5, 4'h4,
                                    4'hA, 4'h3, 4'h2, 4'h1};
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  state_t state, state_nx;
  logic [3:0]    sync1, sync2;
  logic [DW-1:0] div;
  logic [1:0]    row;
  logic [15:0]   snap, full;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    cand, cand_nx, idx, code;
  logic [4:0]    nlow;
  logic          latch, eos, none, single, accept;
  assign latch  = div == DW'(SCAN_DIV - 1);
  assign eos    = latch && row == 2'd3;
  assign full   = {sync2, snap[11:0]};
  assign none   = nlow == 5'd0;
  assign single = nlow == 5'd1;
  assign code   = KEYMAP[{idx, 2'b00} +: 4];
  // classify the completed snapshot: number of pressed keys and the index of one of them
  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++)
      if (!full[i]) begin
        nlow = nlow + 5'd1;
        idx  = 4'(i);
      end
  end
  // debounce decisions, taken once per full scan
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    if (eos)
      case (state)
        IDLE:
          if (single) begin
            cand_nx = code;
            cnt_nx  = CW'(1);
            accept  = DEBOUNCE == 1;
            state_nx = (DEBOUNCE == 1) ? HELD : PRESS_DB;
          end
        PRESS_DB:
          if (single && code == cand) begin
            cnt_nx = cnt + 1'b1;
            accept = cnt_nx == CW'(DEBOUNCE);
            state_nx = accept ? HELD : PRESS_DB;
          end else
            state_nx = IDLE;
        HELD:
          if (none) begin
            cnt_nx   = CW'(1);
            state_nx = (DEBOUNCE == 1) ? IDLE : REL_DB;
          end
        REL_DB:
          if (none) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = (cnt_nx == CW'(DEBOUNCE)) ? IDLE : REL_DB;
          end else
            state_nx = HELD;
      endcase
  end
  // scan timing, column sampling, FSM state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1       <= '1;
      sync2       <= '1;
      div         <= '0;
      row         <= '0;
      row_n       <= 4'b1110;
      snap        <= '1;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      bcd_out     <= '0;
      digit_count <= '0;
    end else begin
      sync1 <= col_n;
      sync2 <= sync1;
      div   <= latch ? '0 : div + 1'b1;
      if (latch) begin
        snap[{row, 2'b00} +: 4] <= sync2;
        row   <= row + 2'd1;
        row_n <= {row_n[2:0], row_n[3]};
      end
      state     <= state_nx;
      cnt       <= cnt_nx;
      cand      <= cand_nx;
      key_valid <= accept;
      if (accept)
        key_code <= cand_nx;
      if (clear) begin
        bcd_out     <= '0;
        digit_count <= '0;
      end else if (accept && cand_nx <= 4'd9) begin
        bcd_out     <= {bcd_out[11:0], cand_nx};
        digit_count <= (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
      end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scan-level reference model of keypad entry with directed and random key sequences
module tb_keypad_scanner;
  localparam int D = 2;
  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid;
  logic [15:0] bcd_out;
  logic [2:0]  digit_count;
  logic [15:0] pressed = '0;
  int vectors = 0, miscompares = 0;
  bit armed = 1'b1;
  int streak = 0, prev = -2, m_cnt = 0;
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_code = '0;
  logic [3:0]  keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(D)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .bcd_out(bcd_out), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // keypad: a pressed key shorts its active row onto its column
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    armed = 1'b1; streak = 0; prev = -2;
    m_bcd = '0; m_cnt = 0; m_code = '0;
  endtask

  task automatic check_reset_values();
    check("rst_row_n", 16'(row_n), 16'hE);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_key_code", 16'(key_code), 16'h0);
    check("rst_bcd_out", bcd_out, 16'h0);
    check("rst_digit_count", 16'(digit_count), 16'h0);
  endtask

  // hold a key set for one full scan; a press is accepted after D identical single-key
  // scans while armed, and re-arming needs D consecutive empty scans
  task automatic scan(input logic [15:0] keys, input bit clr);
    int cls, idx;
    bit acc;
    logic [3:0] exp_row;
    pressed = keys;
    idx = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    cls = (keys == 0) ? -1 : (($countones(keys) == 1) ? idx : 16);
    streak = (cls == prev) ? streak + 1 : 1;
    prev = cls;
    acc = armed && cls >= 0 && cls < 16 && streak == D;
    if (acc) armed = 1'b0;
    else if (!armed && cls == -1 && streak >= D) armed = 1'b1;
    if (acc) begin
      m_code = keymap[idx];
      if (m_code <= 4'd9) begin
        m_bcd = (m_bcd << 4) | 16'(m_code);
        m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      end
    end
    if (clr) begin m_bcd = '0; m_cnt = 0; end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) clear = clr;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_row = 4'hF ^ (4'b0001 << (((i + 1) / 4) % 4));
      check("row_n", 16'(row_n), 16'(exp_row));
      check("key_valid", 16'(key_valid), 16'(acc && i == 15));
    end
    check("key_code", 16'(key_code), 16'(m_code));
    check("bcd_out", bcd_out, m_bcd);
    check("digit_count", 16'(digit_count), 16'(m_cnt));
  endtask

  initial begin
    int k, n, g;
    int digits [5] = '{0, 1, 2, 4, 10};
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk) rst_n = 1'b1;
    // clean press of "5"
    repeat (6) scan(16'(1 << 5), 1'b0);
    repeat (3) scan('0, 1'b0);
    // digits 1,2,3,4,9 then "A"
    foreach (digits[j]) begin
      repeat (3) scan(16'(1 << digits[j]), 1'b0);
      repeat (4) scan('0, 1'b0);
    end
    repeat (3) scan(16'(1 << 3), 1'b0);
    repeat (4) scan('0, 1'b0);
    // short "7", then "7" with a one-scan dropout, then "1"+"2" together
    scan(16'(1 << 8), 1'b0);
    repeat (3) scan('0, 1'b0);
    repeat (2) scan(16'(1 << 8), 1'b0);
    scan('0, 1'b0);
    repeat (2) scan(16'(1 << 8), 1'b0);
    repeat (3) scan('0, 1'b0);
    repeat (4) scan(16'h0003, 1'b0);
    repeat (2) scan('0, 1'b0);
    // clear coinciding with acceptance of "8"
    scan(16'(1 << 9), 1'b0);
    scan(16'(1 << 9), 1'b1);
    repeat (3) scan('0, 1'b0);
    // random presses, bounces, chords and clears
    for (int it = 0; it < 14; it++) begin
      k = $urandom_range(0, 15);
      n = $urandom_range(1, 3);
      repeat (n) scan(16'(1 << k), $urandom_range(0, 7) == 0);
      g = $urandom_range(1, 3);
      repeat (g) scan(($urandom_range(0, 3) == 0) ? 16'((1 << k) | (1 << ((k + 5) % 16))) : 16'h0,
                      $urandom_range(0, 7) == 0);
    end
    repeat (3) scan('0, 1'b0);
    // reset during press debounce of "3" while row 2 is driven
    scan(16'(1 << 2), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("mid_row_n", 16'(row_n), 16'hB);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    repeat (3) scan(16'(1 << 2), 1'b0);
    repeat (2) scan('0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces it, and assembles the entered digits into a 16-bit packed-BCD word. It is the input-side counterpart of the multiplexed 7-segment anode scanner: it drives rows the way the display path drives anodes, and reads columns back. `bcd_out` connects directly to the display path's 16-bit BCD input, so typed digits appear on the 4-digit display.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each row stays active; minimum 4.
- `DEBOUNCE`, default 4: consecutive identical full-scan results needed to accept a press or a release; minimum 1.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `row_n`  out  4  row drive, active low, exactly one bit low at all times
- `col_n`  in  4  column sense, active low, asynchronous to `clk`
- `clear`  in  1  synchronous clear of `bcd_out` and `digit_count`
- `key_valid`  out  1  one-cycle pulse per accepted key press
- `key_code`  out  4  code of the last accepted key; held between pulses
- `bcd_out`  out  16  entered digits, newest in [3:0]
- `digit_count`  out  3  digits entered since reset or clear; saturates at 4

## Operation
- **Key map** (row r = `row_n[r]` low, column c = `col_n[c]` low):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- **Column synchronizer:** `col_n` passes through a 2-flop synchronizer. Only the synchronized value is used.
- **Row scan:**
  - A counter runs 0..`SCAN_DIV`-1 and wraps.
  - On the edge where the counter equals `SCAN_DIV`-1, the synchronized columns are latched as the current row's 4 bits of a 16-bit snapshot.
  - On that same edge `row_n` rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- **End of scan:** the edge that latches row 3 is the end-of-scan. There the snapshot is classified as:
  - NONE: no bit is low.
  - SINGLE(k): exactly one bit is low, giving key k.
  - MULTI: two or more bits are low.
- **Debounce FSM** (evaluated only at end-of-scan; `cnt` counts scans):
  - **IDLE**
    - SINGLE(k): set cand=k, cnt=1, go to PRESS_DB. If `DEBOUNCE`=1, accept immediately instead.
    - NONE or MULTI: stay.
  - **PRESS_DB**
    - SINGLE(cand): cnt+1. When cnt reaches `DEBOUNCE`, accept and go to HELD.
    - Anything else: go to IDLE.
  - **HELD**
    - NONE: cnt=1, go to REL_DB. If `DEBOUNCE`=1, go straight to IDLE.
    - SINGLE or MULTI: stay. No repeat.
  - **REL_DB**
    - NONE: cnt+1. When cnt reaches `DEBOUNCE`, go to IDLE.
    - SINGLE or MULTI: go to HELD. No new pulse.
- **Accept** (all on the edge following end-of-scan):
  - `key_valid`=1 for exactly one cycle.
  - `key_code`=cand.
  - If cand <= 9: `bcd_out` <= {`bcd_out`[11:0], cand}, and `digit_count` increments, saturating at 4.
  - If cand >= 0xA: `bcd_out` and `digit_count` are unchanged.
- **Clear:** `clear`=1 sets `bcd_out`=0 and `digit_count`=0 on the next edge.
  - Clear takes priority over a simultaneous digit shift: the result is 0.
  - `key_valid` and `key_code` still update normally when clear coincides with an accept.
- **Reset values:** `row_n`=1110, `key_valid`=0, `key_code`=0, `bcd_out`=0, `digit_count`=0, FSM=IDLE, scan counter=0, snapshot=all ones, synchronizer=all ones.

## Timing
- One row dwell = `SCAN_DIV` cycles; one full scan = 4·`SCAN_DIV` cycles.
- Columns must be stable at least 2 cycles before a row's latch edge. Bounce shorter than the dwell can therefore corrupt at most one scan.
- **Press latency**, from a clean stable press to `key_valid`: between (`DEBOUNCE`-1)·4·`SCAN_DIV` + 1 and `DEBOUNCE`·4·`SCAN_DIV` + 3 cycles.
- **Release latency:** `DEBOUNCE` consecutive empty scans before IDLE.
- `key_valid` is registered and never high on two consecutive cycles.
- **Reset mid-scan:** `rst_n` low forces all reset values immediately, asynchronously. Scanning restarts at row 0 on the first edge after release. Any partially debounced key is discarded.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE`=2, so a full scan is 16 cycles. The keypad model pulls `col_n[c]` low while `row_n[r]` is low and key (r,c) is pressed.

- **Clean press:** press "5" for 6 scans, then release -> exactly one `key_valid` pulse, `key_code`=5, `bcd_out`=0x0005, `digit_count`=1.
- **Digit entry:** enter keys 1, 2, 3, 4, 9, each a clean press with 4 idle scans between -> `bcd_out`=0x2349, `digit_count`=4. Then press "A" -> `key_code`=0xA, `bcd_out` still 0x2349.
- **Bounce rejection:**
  - Press "7" for exactly 1 scan -> no `key_valid`.
  - Hold "7", drop it for 1 scan, hold again -> exactly one pulse.
  - Hold "1" and "2" together -> no pulse (MULTI).
- **Clear collision:** assert `clear` on the same cycle `key_valid` fires for "8" -> `bcd_out`=0, `digit_count`=0, `key_code`=8.
- **Reset mid-operation:** assert `rst_n` low during PRESS_DB for "3", with `row_n`=1011 -> outputs immediately take reset values (`row_n`=1110). After release with the key still held, one pulse for "3" arrives after about 2 full scans.
